mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Main-memory stage directly downstream of the memory address register: takes the 8-bit address it holds,
//   performs one read or write per request and returns read data toward the memory buffer register.
// - Owns the program/data store (2^ADDR_W x DATA_W), a wait-state sequencer and a busy/done handshake.
// - The control unit stalls its microstep until done, so slow memory timing is modelled without changing the CPU.
// PARAMETERS
// - ADDR_W       8   address width; the store has 2^ADDR_W words
// - DATA_W       16  word width (8-bit opcode + 8-bit operand)
// - WAIT_STATES  2   extra cycles per access, 0..15
// - RD_BIT       3   control_signal bit index that requests a read
// - WR_BIT       4   control_signal bit index that requests a write
// PORTS
// - clk           in   1       rising-edge clock
// - rst           in   1       asynchronous, active-high reset
// - control_signal in  32      control word; only RD_BIT and WR_BIT are used
// - from_MAR      in   ADDR_W  access address
// - from_MBR      in   DATA_W  write data
// - load_en       in   1       program-load write strobe, from test/boot logic
// - load_addr     in   ADDR_W  program-load address
// - load_data     in   DATA_W  program-load data
// - to_MBR        out  DATA_W  registered read data, held until the next read completes
// - mem_busy      out  1       access in progress
// - mem_done      out  1       one-cycle pulse when an access completes
// - mem_err       out  1       sticky flag: RD and WR were requested together; cleared only by rst
// BEHAVIOUR
// - Reset: the FSM goes to IDLE; to_MBR=0, mem_busy=0, mem_done=0, mem_err=0, wait counter=0.
//   Store contents are not cleared.
// - FSM states and transitions:
//   IDLE -> WAIT when exactly one request bit is high;
//   WAIT -> DONE when the counter reaches WAIT_STATES;
//   DONE -> IDLE unconditionally.
// - Request acceptance at edge k in IDLE:
//   - Latch the address, the write data and the direction.
//   - Counter=0. mem_busy=1 from k.
// - WAIT: the counter increments each cycle. When it equals WAIT_STATES, the next edge performs the access:
//   - Read: to_MBR <= mem[addr].
//   - Write: mem[addr] <= data.
//   - At that same edge mem_busy=0 and mem_done=1 (state DONE), so done rises at edge k+WAIT_STATES+1.
//     With WAIT_STATES=0, done rises at k+1.
// - DONE lasts exactly one cycle. Request bits sampled in DONE are ignored; a new request is accepted from IDLE.
// - Requests while busy: ignored. Nothing is queued, and latched address/data are unaffected by input changes.
// - RD and WR both high in IDLE: no access is started, mem_err=1, the FSM stays in IDLE.
// - load_en in IDLE: mem[load_addr] <= load_data at that edge.
//   - Load has priority: a request in the same cycle is dropped, with no busy and no err.
//   - load_en outside IDLE is ignored.
// - rst mid-access: the access is aborted, a pending write is NOT committed, to_MBR returns to 0.
// - Addresses wrap naturally within ADDR_W. No out-of-range case exists.
// - Write-then-read of the same address returns the newly written value. There is no bypass hazard,
//   because accesses are serialised.
// STRUCTURE
// - Shared package cpu_defs_pkg holds:
//   - ADDR_W and DATA_W defaults, CTRL_MEM_RD=3, CTRL_MEM_WR=4;
//   - enum mem_state_t {IDLE, WAIT, DONE};
//   - the 32-bit control_signal width constant.
// - Sub-module mem_array: synchronous 2^ADDR_W x DATA_W store with one write port and one registered read port.
//   mem_access_unit muxes the load path and the access path onto the write port.
// - Counter width is $clog2(WAIT_STATES+1), minimum 1.
// TESTING
// - Load, then read: load 0x05=0xA53C; with WAIT_STATES=2 assert RD (bit3) with MAR=0x05.
//   Expect busy for 3 cycles, done 1 cycle, to_MBR=0xA53C.
// - Write, then read back: WR with MAR=0x10, MBR=0x1234. After done, RD at 0x10 -> to_MBR=0x1234.
//   to_MBR keeps its old value throughout the write.
// - Both request bits: RD=WR=1 -> no busy, mem_err=1 and it stays 1.
//   A following RD still completes normally.
// - Reset abort: WR 0x20=0xBEEF with WAIT_STATES=2; pulse rst after 1 cycle of busy.
//   Expect busy=0, to_MBR=0; a later read of 0x20 returns the pre-loaded 0x0000.
// - Busy-ignore and wrap: RD 0xFF; change MAR to 0x00 and toggle RD during busy.
//   Result = mem[0xFF] and exactly one done pulse.
// - Zero-wait and load priority: WAIT_STATES=0: RD -> done at k+1.
//   load_en together with RD -> the word is written and no busy is raised.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: default widths, control-word bit positions and the
// memory access state encoding.
package cpu_defs_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int CTRL_W      = 32;
  localparam int CTRL_MEM_RD = 3;
  localparam int CTRL_MEM_WR = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

  typedef enum logic {
    DIR_RD,
    DIR_WR
  } mem_dir_t;

  // Wait-state counter must hold 0..wait_states; never narrower than one bit.
  function automatic int cnt_width(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the control path (MAR/MBR side) and the
// memory access unit, plus the boot-time program-load strobe.
interface mem_access_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic [cpu_defs_pkg::CTRL_W-1:0] control_signal;
  logic [ADDR_W-1:0]               from_MAR;
  logic [DATA_W-1:0]               from_MBR;
  logic                            load_en;
  logic [ADDR_W-1:0]               load_addr;
  logic [DATA_W-1:0]               load_data;
  logic [DATA_W-1:0]               to_MBR;
  logic                            mem_busy;
  logic                            mem_done;
  logic                            mem_err;

  modport master (
    output control_signal, from_MAR, from_MBR, load_en, load_addr, load_data,
    input  to_MBR, mem_busy, mem_done, mem_err
  );

  modport slave (
    input  control_signal, from_MAR, from_MBR, load_en, load_addr, load_data,
    output to_MBR, mem_busy, mem_done, mem_err
  );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-write-port store with one registered read port
// (read-before-write on a same-address collision).
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the store and its read register have no reset; contents must survive
  // a reset and a resettable array would not map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// Main-memory stage: serialises one read or write per request behind a
// configurable number of wait states and reports busy/done/err to the control unit.
module mem_access_unit
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 2,
  parameter int RD_BIT      = CTRL_MEM_RD,
  parameter int WR_BIT      = CTRL_MEM_WR
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int               CNT_W    = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  mem_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  mem_dir_t          dir_q;
  logic [DATA_W-1:0] to_mbr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              rd_req;
  logic              wr_req;
  logic              access_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_ctrl;

  assign rd_req      = bus.control_signal[RD_BIT];
  assign wr_req      = bus.control_signal[WR_BIT];
  assign unused_ctrl = ^bus.control_signal;
  assign access_last = (state_q == WAIT) && (cnt_q == CNT_LAST);

  // Read address follows the MAR while idle so that the array's registered
  // output already holds mem[addr] by the first wait cycle (needed for zero wait states).
  assign mem_raddr = (state_q == IDLE) ? bus.from_MAR : addr_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave it unassigned and infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = data_q;
    if (state_q == IDLE && bus.load_en) begin
      mem_we    = 1'b1;
      mem_waddr = bus.load_addr;
      mem_wdata = bus.load_data;
    end else if (access_last && dir_q == DIR_WR) begin
      mem_we = 1'b1;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      dir_q    <= DIR_RD;
      to_mbr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (!bus.load_en) begin
            if (rd_req && wr_req) begin
              err_q <= 1'b1;
            end else if (rd_req || wr_req) begin
              state_q <= WAIT;
              addr_q  <= bus.from_MAR;
              data_q  <= bus.from_MBR;
              dir_q   <= wr_req ? DIR_WR : DIR_RD;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (dir_q == DIR_RD) begin
              to_mbr_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.to_MBR   = to_mbr_q;
  assign bus.mem_busy = busy_q;
  assign bus.mem_done = done_q;
  assign bus.mem_err  = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one instance with two wait states and
// one with zero, exercised one at a time.
module tb_mem_access_unit;
  import cpu_defs_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam logic [31:0] RD   = 32'd1 << CTRL_MEM_RD;
  localparam logic [31:0] WR   = 32'd1 << CTRL_MEM_WR;
  localparam logic [31:0] BOTH = RD | WR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_ws2 ();
  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_ws0 ();

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(2)) u_dut_ws2 (
    .clk (clk),
    .rst (rst),
    .bus (bus_ws2)
  );

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) u_dut_ws0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_ws0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;  // 0: two-wait-state instance, 1: zero-wait-state instance

  logic [DW-1:0] model   [2][256];
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] exp_q   [$];

  logic          obs_busy, obs_done, obs_err;
  logic [DW-1:0] obs_mbr;
  assign obs_busy = (sel == 0) ? bus_ws2.mem_busy : bus_ws0.mem_busy;
  assign obs_done = (sel == 0) ? bus_ws2.mem_done : bus_ws0.mem_done;
  assign obs_err  = (sel == 0) ? bus_ws2.mem_err  : bus_ws0.mem_err;
  assign obs_mbr  = (sel == 0) ? bus_ws2.to_MBR   : bus_ws0.to_MBR;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] ctrl, input logic [AW-1:0] mar, input logic [DW-1:0] mbr,
                       input logic ld, input logic [AW-1:0] la, input logic [DW-1:0] ldd);
    if (sel == 0) begin
      bus_ws2.control_signal = ctrl; bus_ws2.from_MAR = mar; bus_ws2.from_MBR = mbr;
      bus_ws2.load_en = ld; bus_ws2.load_addr = la; bus_ws2.load_data = ldd;
    end else begin
      bus_ws0.control_signal = ctrl; bus_ws0.from_MAR = mar; bus_ws0.from_MBR = mbr;
      bus_ws0.load_en = ld; bus_ws0.load_addr = la; bus_ws0.load_data = ldd;
    end
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive('0, '0, '0, 1'b1, a, d);
    model[sel][a] = d;
    @(negedge clk);
    drive('0, '0, '0, 1'b0, '0, '0);
  endtask

  // Issue a single-cycle request and push the value to_MBR must show at done.
  task automatic request(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (is_wr) begin
      exp_q.push_back(last_rd[sel]);
      model[sel][a] = d;
    end else begin
      exp_q.push_back(model[sel][a]);
      last_rd[sel] = model[sel][a];
    end
    drive(is_wr ? WR : RD, a, d, 1'b0, '0, '0);
    @(negedge clk);
    drive('0, a, d, 1'b0, '0, '0);
  endtask

  // Wait (bounded) for done; optionally wiggle MAR and RD while busy.
  task automatic await_done(input string tag, input int exp_busy, input bit disturb);
    int busy_n = 0;
    int t = 0;
    while (!obs_done && t < 40) begin
      if (obs_busy) busy_n++;
      if (disturb) drive((t % 2 == 0) ? RD : 32'd0, 8'h00, 16'hFFFF, 1'b0, '0, '0);
      @(negedge clk);
      t++;
    end
    if (disturb) drive('0, '0, '0, 1'b0, '0, '0);
    check({tag, "_done"}, {31'd0, obs_done}, 32'd1);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    if (exp_q.size() > 0) check({tag, "_mbr"}, {16'd0, obs_mbr}, {16'd0, exp_q.pop_front()});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, obs_done}, 32'd0);
  endtask

  initial begin
    int extra_done;
    rst = 1'b1;
    sel = 1; drive('0, '0, '0, 1'b0, '0, '0);
    sel = 0; drive('0, '0, '0, 1'b0, '0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      check($sformatf("rst_busy%0d", s), {31'd0, obs_busy}, 32'd0);
      check($sformatf("rst_done%0d", s), {31'd0, obs_done}, 32'd0);
      check($sformatf("rst_err%0d", s),  {31'd0, obs_err},  32'd0);
      check($sformatf("rst_mbr%0d", s),  {16'd0, obs_mbr},  32'd0);
    end

    // Load then read with two wait states.
    sel = 0;
    load_word(8'h05, 16'hA53C);
    load_word(8'h20, 16'h0000);
    load_word(8'hFF, 16'h7E11);
    load_word(8'h00, 16'h0102);
    request(1'b0, 8'h05, '0);
    await_done("load_read", 3, 1'b0);

    // Write, then read back; to_MBR holds the earlier read across the write.
    request(1'b1, 8'h10, 16'h1234);
    await_done("write", 3, 1'b0);
    request(1'b0, 8'h10, '0);
    await_done("readback", 3, 1'b0);

    // Both request bits: error, no access; error is sticky.
    drive(BOTH, 8'h05, 16'h5555, 1'b0, '0, '0);
    @(negedge clk);
    drive('0, '0, '0, 1'b0, '0, '0);
    check("both_busy", {31'd0, obs_busy}, 32'd0);
    check("both_err", {31'd0, obs_err}, 32'd1);
    repeat (3) @(negedge clk);
    check("both_err_sticky", {31'd0, obs_err}, 32'd1);
    request(1'b0, 8'h05, '0);
    await_done("after_err_read", 3, 1'b0);
    check("err_still_set", {31'd0, obs_err}, 32'd1);

    // Reset during a write: aborted, nothing committed.
    drive(WR, 8'h20, 16'hBEEF, 1'b0, '0, '0);
    @(negedge clk);
    drive('0, '0, '0, 1'b0, '0, '0);
    check("abort_busy_pre", {31'd0, obs_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, obs_busy}, 32'd0);
    check("abort_mbr", {16'd0, obs_mbr}, 32'd0);
    check("abort_err", {31'd0, obs_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    request(1'b0, 8'h20, '0);
    await_done("abort_readback", 3, 1'b0);

    // Busy-ignore with top-of-range address; input wiggles must not requeue.
    request(1'b0, 8'hFF, '0);
    await_done("busy_ignore", 3, 1'b1);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (obs_done) extra_done++;
    end
    check("busy_ignore_extra_done", extra_done, 0);
    check("busy_ignore_mbr_hold", {16'd0, obs_mbr}, 32'h7E11);

    // Zero wait states: done one edge after acceptance.
    sel = 1;
    load_word(8'h33, 16'hC0DE);
    request(1'b0, 8'h33, '0);
    await_done("ws0_read", 1, 1'b0);

    // Load has priority over a same-cycle request.
    drive(RD, 8'h33, '0, 1'b1, 8'h44, 16'h5A5A);
    model[1][8'h44] = 16'h5A5A;
    @(negedge clk);
    drive('0, '0, '0, 1'b0, '0, '0);
    check("ld_prio_busy", {31'd0, obs_busy}, 32'd0);
    check("ld_prio_err", {31'd0, obs_err}, 32'd0);
    @(negedge clk);
    check("ld_prio_done", {31'd0, obs_done}, 32'd0);
    request(1'b0, 8'h44, '0);
    await_done("ld_prio_read", 1, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
